bp_me_wormhole_packet_rx: RTL and testbench
===========================================

Name: bp_me_wormhole_packet_rx

Overview:
- Receive-side endpoint of a coherence-network wormhole link: consumes flits from a ready-and link and reassembles one wormhole packet {payload, len, cord}.
- Presents the packet with valid/yumi to the consuming engine, e.g. a CCE or accelerator command sink.
- Counterpart of the transmit-only router adapter that serializes packets onto the link.
- Single packet buffer; the transmit half of the link is tied off.

Parameters:
flit_width_p, 64, link flit data width
cord_width_p, 7, coordinate field width (packet bits [cord_width_p-1:0])
len_width_p, 4, length field width (packet bits [cord_width_p+:len_width_p]), counts flits after the header
max_payload_width_p, 128, payload width; packet_width_lp = cord_width_p+len_width_p+max_payload_width_p
(derived) max_flits_lp = ceil(packet_width_lp/flit_width_p); max_len_lp = max_flits_lp-1

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
link_i  in  flit_width_p+2  {v, data[flit_width_p-1:0], ready_and_rev}; v/data are the incoming flit; ready_and_rev ignored
link_o  out  flit_width_p+2  {v=0, data=0, ready_and_rev}; ready_and_rev = flit accept
packet_o  out  packet_width_lp  reassembled packet; flit k occupies bits [k*flit_width_p +: flit_width_p], truncated at packet_width_lp
v_o  out  1  packet valid
yumi_i  in  1  consumer takes packet; legal only when v_o=1
error_o  out  1  sticky: a header arrived with len > max_len_lp

Behaviour:
- Reset: state=e_header, count=0, packet buffer=0, v_o=0, error_o=0, link_o.ready_and_rev=0 on the reset cycle, then 1.
- Flit accepted when link_i.v & link_o.ready_and_rev (ready-and: ready is not a function of v).
- FSM:
  - e_header: ready=1. On accept: clear the buffer, write the flit to slot 0, latch len from flit bits [cord_width_p+:len_width_p], count=1. Next state is e_full if len==0, else e_body.
  - e_body: ready=1. On accept: write the flit to slot count if count<max_flits_lp, else drop the data; count++. When count==len (last flit accepted), go to e_full.
  - e_full: v_o=1, ready=0. On yumi_i, go to e_header and set v_o=0 next cycle.
- Latency: v_o rises the cycle after the last flit is accepted. A single-flit packet is accepted in cycle t and valid in cycle t+1.
- packet_o holds stable while v_o=1; only bits of received slots are nonzero.
- Oversize len (> max_len_lp):
  - error_o set on the header-accept cycle and held until reset.
  - All len+1 flits are still consumed to keep the link in sync; flits beyond max_flits_lp are discarded.
- Counter is len_width_p+1 bits; no wrap for len = 2^len_width_p-1.
- Link stalls: no flit is accepted while in e_full. Upstream holds v/data (wormhole contract); no flit loss.
- reset_i mid-packet: partial packet discarded, FSM to e_header, error_o cleared.
- yumi_i with v_o=0: illegal; FSM ignores it.

Optional Feature:
BP_ME_WORMHOLE_RX_BYPASS_EN
- Defined: in e_full, link_o.ready_and_rev = yumi_i. A header flit accepted in the same cycle as yumi_i is processed as in e_header (buffer reloaded, state e_body or e_full). This gives back-to-back packets with no bubble; a stream of single-flit packets sustains 1 packet/cycle.
- Undefined: ready=0 in e_full; at least one idle-link cycle after every yumi_i; single-flit packets run at 1 per 2 cycles.

Test Plan:
- Single-flit packet: flit_width_p=64, header cord=0x05, len=0 in cycle 1 -> v_o=1 in cycle 2, packet_o[63:0]=flit, upper bits 0; yumi in cycle 2 -> v_o=0 in cycle 3.
- 3-flit packet (len=2), flits A, B, C with link_i.v gaps between flits -> v_o only after C is accepted; packet_o={C,B,A} truncated to packet_width_lp; error_o=0.
- Backpressure: second packet offered while v_o=1 with yumi withheld 5 cycles -> ready_and_rev=0 for all 5; first packet_o unchanged; second packet received intact after yumi.
- Oversize: max_flits_lp=3, header len=5 -> error_o=1 from the header cycle; 6 flits consumed; v_o after the 6th; packet_o holds the first 3 flits; the following legal packet is received correctly, error_o stays 1.
- Reset mid-packet: reset_i after the 2nd of 3 flits -> v_o=0, error_o=0, ready=1; the next header is parsed as a fresh packet.
- With BP_ME_WORMHOLE_RX_BYPASS_EN, a stream of 4 single-flit packets with yumi_i held at 1 -> 4 packets in 4 consecutive valid cycles; without the macro -> 8 cycles.

Source files
------------

// File: rtl/bp_me_wormhole_packet_rx.sv
// Wormhole packet receiver: reassembles link flits into one {payload, len, cord} packet for a valid/yumi consumer.
// v_o rises the cycle after the last flit; the link is stalled while full unless BP_ME_WORMHOLE_RX_BYPASS_EN lets a header in on the yumi cycle.
module bp_me_wormhole_packet_rx #(
   parameter int flit_width_p        = 64,
   parameter int cord_width_p        = 7,
   parameter int len_width_p         = 4,
   parameter int max_payload_width_p = 128,
   localparam int packet_width_lp    = cord_width_p + len_width_p + max_payload_width_p,
   localparam int max_flits_lp       = (packet_width_lp + flit_width_p - 1) / flit_width_p,
   localparam int max_len_lp         = max_flits_lp - 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [flit_width_p+1:0]    link_i,
   output logic [flit_width_p+1:0]    link_o,
   output logic [packet_width_lp-1:0] packet_o,
   output logic                       v_o,
   input  logic                       yumi_i,
   output logic                       error_o
);

   typedef enum logic [1:0] {e_header, e_body, e_full} state_e;

   localparam logic [len_width_p:0] max_flits_c = (len_width_p+1)'(max_flits_lp);
   localparam logic [len_width_p:0] max_len_c   = (len_width_p+1)'(max_len_lp);
   localparam logic [len_width_p:0] one_c       = (len_width_p+1)'(1);

   state_e                     state_r, state_n;
   logic [len_width_p:0]       count_r, count_n;
   logic [len_width_p-1:0]     len_r, len_n;
   logic [packet_width_lp-1:0] pkt_r, pkt_n;
   logic                       err_r, err_n;

   logic                       flit_v;
   logic [flit_width_p-1:0]    flit_dat;
   logic [len_width_p-1:0]     flit_len;
   logic [packet_width_lp-1:0] hdr_slot;
   logic [packet_width_lp-1:0] body_slot;
   logic                       ready;
   logic                       accept;
   logic                       take_hdr;
   logic                       bypass_ok;
   logic                       unused_rev;

   assign flit_v     = link_i[flit_width_p+1];
   assign flit_dat   = link_i[flit_width_p:1];
   assign unused_rev = link_i[0];
   assign flit_len   = flit_dat[cord_width_p +: len_width_p];

   // Slots past packet_width_lp shift out entirely, so truncation falls out of the cast.
   assign hdr_slot  = packet_width_lp'(flit_dat);
   assign body_slot = hdr_slot << (int'(count_r) * flit_width_p);

`ifdef BP_ME_WORMHOLE_RX_BYPASS_EN
   assign bypass_ok = yumi_i;
`else
   assign bypass_ok = 1'b0;
`endif

   always_comb begin
      state_n  = state_r;
      count_n  = count_r;
      len_n    = len_r;
      pkt_n    = pkt_r;
      err_n    = err_r;
      ready    = 1'b0;
      v_o      = 1'b0;
      accept   = 1'b0;
      take_hdr = 1'b0;

      unique case (state_r)
         e_header: ready = 1'b1;
         e_body:   ready = 1'b1;
         e_full: begin
            v_o   = 1'b1;
            ready = bypass_ok;
            if (yumi_i) state_n = e_header;
         end
         default: state_n = e_header;
      endcase

      ready    = ready & ~reset_i;
      accept   = flit_v & ready;
      // A full buffer only accepts a flit on the yumi cycle, and that flit is always a header.
      take_hdr = accept & (state_r != e_body);

      if (take_hdr) begin
         pkt_n   = hdr_slot;
         len_n   = flit_len;
         count_n = one_c;
         err_n   = err_r | ({1'b0, flit_len} > max_len_c);
         state_n = (flit_len == '0) ? e_full : e_body;
      end else if (accept) begin
         if (count_r < max_flits_c) pkt_n = pkt_r | body_slot;
         count_n = count_r + one_c;
         if (count_r == {1'b0, len_r}) state_n = e_full;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_header;
         count_r <= '0;
         len_r   <= '0;
         pkt_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         count_r <= count_n;
         len_r   <= len_n;
         pkt_r   <= pkt_n;
         err_r   <= err_n;
      end
   end

   assign link_o   = {1'b0, {flit_width_p{1'b0}}, ready};
   assign packet_o = pkt_r;
   assign error_o  = err_n;

endmodule

// File: tb/tb_bp_me_wormhole_packet_rx.sv
// Bench for bp_me_wormhole_packet_rx: random packets scored against a flit-list model, plus directed latency, stall, oversize, reset and throughput cases.
module tb_bp_me_wormhole_packet_rx;
   localparam int FW   = 64;
   localparam int CW   = 7;
   localparam int LW   = 4;
   localparam int PW   = 128;
   localparam int PKW  = CW + LW + PW;
   localparam int MAXF = (PKW + FW - 1) / FW;
`ifdef BP_ME_WORMHOLE_RX_BYPASS_EN
   localparam bit bypass = 1'b1;
`else
   localparam bit bypass = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_i;
   logic [FW+1:0]  link_i;
   logic [FW+1:0]  link_o;
   logic [PKW-1:0] packet_o;
   logic           v_o;
   logic           yumi_i;
   logic           error_o;

   logic           link_v;
   logic [FW-1:0]  link_dat;
   logic           link_rev;
   wire            ready = link_o[0];

   assign link_i = {link_v, link_dat, link_rev};

   bp_me_wormhole_packet_rx #(
      .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .max_payload_width_p(PW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .link_i(link_i), .link_o(link_o),
      .packet_o(packet_o), .v_o(v_o), .yumi_i(yumi_i), .error_o(error_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PKW-1:0] pkt;
      logic           err;
   } exp_t;

   exp_t sb_q[$];
   int   hs_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   yumi_mode = 1;  // 0 random, 1 always, 2 withhold
   bit   err_model = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Consumer: yumi only ever asserted while v_o is high.
   initial begin
      yumi_i   = 1'b0;
      link_rev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         link_rev = 1'($urandom_range(0, 1));
         yumi_i   = v_o && !reset_i &&
                    (yumi_mode == 1 || (yumi_mode == 0 && $urandom_range(0, 2) == 0));
      end
   end

   // Monitor: score every handshake, and check the packet holds while waiting.
   initial begin
      bit             held;
      logic [PKW-1:0] held_pkt;
      exp_t           e;
      held = 1'b0;
      held_pkt = '0;
      forever begin
         @(negedge clk);
         if (reset_i || !v_o) begin
            held = 1'b0;
         end else begin
            if (held) chk("hold_stable", packet_o, held_pkt);
            if (yumi_i) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_valid", sb_q.size(), 1);
               end else begin
                  e = sb_q.pop_front();
                  chk("packet", packet_o, e.pkt);
                  chk("error", error_o, e.err);
                  hs_q.push_back(cyc);
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               held_pkt = packet_o;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the flit was taken.
   task automatic drive_flit(input logic [FW-1:0] d);
      bit ok;
      ok = 1'b0;
      link_v   = 1'b1;
      link_dat = d;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", ok, 1);
         finish_tb();
      end
      @(posedge clk);
      #1;
      link_v   = 1'b0;
      link_dat = {$urandom, $urandom};
   endtask

   task automatic send_pkt(input int len, input int gaps);
      logic [FW-1:0]      fl[16];
      logic [MAXF*FW-1:0] acc;
      exp_t               e;
      acc = '0;
      for (int k = 0; k <= len; k++) begin
         fl[k] = {$urandom, $urandom};
         if (k == 0) begin
            fl[k][CW+:LW]  = LW'(len);
            fl[k][CW-1:0]  = CW'($urandom);
         end
         if (k < MAXF) acc[k*FW +: FW] = fl[k];
      end
      err_model = err_model | (len > MAXF - 1);
      e.pkt = acc[PKW-1:0];
      e.err = err_model;
      sb_q.push_back(e);
      for (int k = 0; k <= len; k++) begin
         drive_flit(fl[k]);
         chk("v_after_flit", v_o, (k == len));
         if (k == 0) chk("err_on_header", error_o, err_model);
         if (k != len && (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)))
            repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", sb_q.size(), 0);
   endtask

   initial begin
      logic [PKW-1:0] saved;
      reset_i  = 1'b1;
      link_v   = 1'b0;
      link_dat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready_low", ready, 0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("reset_v", v_o, 0);
      chk("reset_err", error_o, 0);
      chk("reset_ready_high", ready, 1);
      chk("reset_packet", packet_o, 0);
      chk("link_o_v_data", link_o[FW+1:1], 0);
      @(posedge clk);
      #1;

      // Single flit: valid the next cycle, gone the cycle after yumi.
      yumi_mode = 1;
      send_pkt(0, 0);
      @(posedge clk);
      #1;
      chk("single_v_drop", v_o, 0);

      // Three flits with idle link cycles between them.
      send_pkt(2, 1);
      wait_drain();

      yumi_mode = 0;
      repeat (30) send_pkt($urandom_range(0, 2), 2);
      wait_drain();

      // Backpressure: next header offered while the buffer is full and unconsumed.
      yumi_mode = 2;
      send_pkt($urandom_range(0, 2), 0);
      saved = sb_q[0].pkt;
      fork
         begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_ready", ready, 0);
               chk("bp_hold", packet_o, saved);
            end
            yumi_mode = 1;
         end
         send_pkt($urandom_range(0, 2), 0);
      join
      wait_drain();

      // Oversize header, then a legal packet; error stays set.
      yumi_mode = 0;
      send_pkt(5, 1);
      send_pkt(1, 0);
      wait_drain();

      // Reset after the second of three flits.
      yumi_mode = 1;
      drive_flit({$urandom, 21'($urandom), LW'(2), CW'($urandom)});
      drive_flit({$urandom, $urandom});
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      err_model = 1'b0;
      @(negedge clk);
      chk("midrst_v", v_o, 0);
      chk("midrst_err", error_o, 0);
      chk("midrst_ready", ready, 1);
      @(posedge clk);
      #1;
      send_pkt(2, 0);
      wait_drain();

      yumi_mode = 0;
      repeat (20) send_pkt(($urandom_range(0, 3) == 0) ? $urandom_range(3, 15) : $urandom_range(0, 2), 2);
      wait_drain();

      // Throughput: four single-flit packets, consumer always ready.
      yumi_mode = 1;
      hs_q.delete();
      repeat (4) send_pkt(0, 0);
      wait_drain();
      chk("tput_count", hs_q.size(), 4);
      chk("tput_span", hs_q[3] - hs_q[0], bypass ? 3 : 6);

      chk("sb_empty", sb_q.size(), 0);
      finish_tb();
   end

   initial begin
      #400000;
      checks++;
      failures++;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      finish_tb();
   end
endmodule
